vadd_issue_ctrl: RTL

Issue and operand-fetch stage directly upstream of the serialized 16-lane vector adder. Holds an 8-entry × 256-bit vector register file, accepts three-address add instructions over a valid/ready handshake, drives the adder's operand and `start` inputs, waits for its `done`, and writes the 256-bit sum back to the destination register. Also maintains a sticky lane-overflow flag and a done-timeout error flag for the surrounding datapath.

---
 rtl/vadd_pkg.sv | 17 +
 rtl/vreg_file.sv | 36 +++
 rtl/vadd_issue_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vadd_pkg.sv
// Shared types and constants for the vector-add issue stage.
package vadd_pkg;

  localparam int VW              = 256;
  localparam int LANES           = 16;
  localparam int LANE_W          = 16;
  localparam int RAW             = 3;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN,
    WB
  } state_t;

endpackage

// File: rtl/vreg_file.sv
// Vector register file: one synchronous write port, three combinational reads.
module vreg_file
  import vadd_pkg::*;
#(
  parameter int W     = VW,
  parameter int NREGS = 8,
  parameter int AW    = RAW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd2,
  input  logic [AW-1:0] ra3,
  output logic [W-1:0]  rd3
);

  logic [W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign rd3 = mem[ra3];

endmodule

// File: rtl/vadd_issue_ctrl.sv
// Issue/operand-fetch controller in front of the serialized 16-lane vector adder.
module vadd_issue_ctrl
  import vadd_pkg::*;
#(
  parameter int W       = VW,
  parameter int NREGS   = 8,
  parameter int AW      = RAW,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_src1,
  input  logic [AW-1:0] instr_src2,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  add_in1,
  output logic [W-1:0]  add_in2,
  output logic          add_start,
  input  logic [W-1:0]  add_sum,
  input  logic          add_ovf,
  input  logic          add_done,
  output logic          busy,
  output logic          cmp_valid,
  output logic          ovf_sticky,
  input  logic          ovf_clr,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, nxt;
  logic [AW-1:0]   dst_q, src1_q, src2_q;
  logic [W-1:0]    src1_data, src2_data, sum_q;
  logic            ovf_q;
  logic [CW-1:0]   tcnt;
  logic            accept, tmo_hit, wb_we, rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [W-1:0]    rf_wdata;

  assign accept  = instr_valid && instr_ready;
  assign tmo_hit = (state == RUN) && !add_done && (tcnt == CW'(TIMEOUT - 1));
  assign wb_we   = (state == WB);

  // Writeback owns the single write port; a colliding host load is dropped.
  assign rf_we    = wb_we || ld_en;
  assign rf_waddr = wb_we ? dst_q : ld_addr;
  assign rf_wdata = wb_we ? sum_q : ld_data;

  vreg_file #(.W(W), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra1   (src1_q),
    .rd1   (src1_data),
    .ra2   (src2_q),
    .rd2   (src2_data),
    .ra3   (rd_addr),
    .rd3   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = FETCH;
      FETCH:   nxt = RUN;
      RUN:     if (add_done) nxt = WB;
               else if (tmo_hit) nxt = IDLE;
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) && !rst;
    busy        = (state != IDLE);
    add_start   = (state == RUN);
    cmp_valid   = (state == WB);
  end

  // Datapath registers; operands are frozen at FETCH so later host loads cannot disturb a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      add_in1     <= '0;
      add_in2     <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      tcnt        <= '0;
      ovf_sticky  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        dst_q  <= instr_dst;
        src1_q <= instr_src1;
        src2_q <= instr_src2;
      end
      if (state == FETCH) begin
        add_in1 <= src1_data;
        add_in2 <= src2_data;
        tcnt    <= '0;
      end
      if (state == RUN) begin
        tcnt <= tcnt + 1'b1;
        if (add_done) begin
          sum_q <= add_sum;
          ovf_q <= add_ovf;
        end
      end
      if (tmo_hit) timeout_err <= 1'b1;
      ovf_sticky <= (ovf_sticky && !ovf_clr) || (wb_we && ovf_q);
    end
  end

endmodule
